medidor_frecuencia: RTL and testbench

MEDIDOR_FRECUENCIA -- requirements
Module: medidor_frecuencia

---
 rtl/medidor_frecuencia_if.sv | 11 +
 rtl/medidor_frecuencia.sv | 80 ++++++++
 tb/tb_medidor_frecuencia.sv | 119 +++++++++++
 3 files changed

// File: rtl/medidor_frecuencia_if.sv
// medidor_frecuencia_if: control/result bundle; master drives enable/sig_in, slave returns periodo/donde/valido/desborde
interface medidor_frecuencia_if #(parameter int ANCHO = 12);
  logic enable;
  logic sig_in;
  logic [ANCHO-1:0] periodo;
  logic [10:0] donde;
  logic valido;
  logic desborde;
  modport master(output enable, sig_in, input periodo, donde, valido, desborde);
  modport slave(input enable, sig_in, output periodo, donde, valido, desborde);
endinterface

// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: measures sig_in period in clk cycles; ports clk, reset, bus(enable, sig_in in; periodo, donde, valido, desborde out)
module medidor_frecuencia #(parameter int ANCHO = 12) (
  input logic clk,
  input logic reset,
  medidor_frecuencia_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ESPERA, MIDE} state_t;
  localparam logic [ANCHO-1:0] MAX = '1;
  state_t state, state_n;
  logic s1, s2, s3, edge_det;
  logic [ANCHO-1:0] cnt, cnt_n, periodo_q, periodo_n;
  logic [10:0] donde_q, donde_n;
  logic valido_q, valido_n, desborde_q, desborde_n;
  logic [ANCHO+10:0] half;
  assign edge_det = s2 & ~s3;
  assign half = {11'd0, cnt} >> 1;
  assign bus.periodo = periodo_q;
  assign bus.donde = donde_q;
  assign bus.valido = valido_q;
  assign bus.desborde = desborde_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      {s1, s2, s3} <= 3'b000;
      periodo_q <= '0;
      donde_q <= '0;
      valido_q <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      {s1, s2, s3} <= {bus.sig_in, s1, s2};
      periodo_q <= periodo_n;
      donde_q <= donde_n;
      valido_q <= valido_n;
      desborde_q <= desborde_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    periodo_n = periodo_q;
    donde_n = donde_q;
    valido_n = 1'b0;
    desborde_n = desborde_q;
    if (!bus.enable) begin
      state_n = IDLE;
      cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ESPERA;
          cnt_n = '0;
        end
        ESPERA: if (edge_det) begin
          state_n = MIDE;
          cnt_n = ANCHO'(1);
        end
        MIDE: if (edge_det) begin
          periodo_n = cnt;
          donde_n = (half > (ANCHO+11)'(2047)) ? 11'd2047 : half[10:0];
          valido_n = 1'b1;
          desborde_n = 1'b0;
          cnt_n = ANCHO'(1);
        end else if (cnt == MAX) begin
          desborde_n = 1'b1;
          cnt_n = '0;
          state_n = ESPERA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        default: begin
          state_n = IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_medidor_frecuencia.sv
// tb_medidor_frecuencia: randomized and directed period stimulus checked each cycle against a timestamp-based reference model
module tb_medidor_frecuencia;
  localparam int ANCHO = 12;
  localparam int LIM = (1 << ANCHO) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  medidor_frecuencia_if #(.ANCHO(ANCHO)) bus();
  medidor_frecuencia #(.ANCHO(ANCHO)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0, t = 0;
  int hi_len = 10, lo_len = 10, ph = 0;
  bit lvl = 1'b0, stuck = 1'b0;
  bit hist[$] = '{0, 0, 0, 0};
  bit armed = 1'b0;
  int start = -1;
  int m_periodo = 0, m_donde = 0;
  bit m_valido = 1'b0, m_desb = 1'b0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, t, got, exp);
    end
  endtask
  task automatic model();
    bit e;
    m_valido = 1'b0;
    if (reset) begin
      hist.delete();
      repeat (4) hist.push_back(1'b0);
      armed = 1'b0;
      start = -1;
      m_periodo = 0;
      m_donde = 0;
      m_desb = 1'b0;
      return;
    end
    hist.push_back(bus.sig_in);
    if (hist.size() > 8) void'(hist.pop_front());
    e = hist[hist.size()-3] && !hist[hist.size()-4];
    if (!bus.enable) begin
      armed = 1'b0;
      start = -1;
    end else if (!armed) begin
      armed = 1'b1;
    end else if (e) begin
      if (start >= 0) begin
        m_periodo = t - start;
        m_donde = (m_periodo / 2 > 2047) ? 2047 : m_periodo / 2;
        m_valido = 1'b1;
        m_desb = 1'b0;
      end
      start = t;
    end else if (start >= 0 && t - start == LIM) begin
      m_desb = 1'b1;
      start = -1;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    t++;
    model();
    #1;
    chk("periodo", 32'(bus.periodo), m_periodo);
    chk("donde", 32'(bus.donde), m_donde);
    chk("valido", 32'(bus.valido), 32'(m_valido));
    chk("desborde", 32'(bus.desborde), 32'(m_desb));
    if (!stuck) begin
      ph++;
      if (ph >= (lvl ? hi_len : lo_len)) begin
        lvl = !lvl;
        ph = 0;
      end
    end
    bus.sig_in = lvl;
  endtask
  task automatic run(int n);
    repeat (n) tick();
  endtask
  task automatic set_wave(int h, int l);
    hi_len = h;
    lo_len = l;
    stuck = 1'b0;
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.sig_in = 1'b0;
    run(3);
    reset = 1'b0;
    bus.enable = 1'b1;
    set_wave(10, 10); run(300);
    set_wave(1667, 1667); run(11000);
    set_wave(4, 3); run(60);
    set_wave(25, 25); run(200);
    stuck = 1'b1; lvl = 1'b0; run(4300);
    set_wave(25, 25); run(200);
    set_wave(2048, 2047); run(12500);
    set_wave(50, 50); run(250);
    reset = 1'b1; run(1); reset = 1'b0; run(300);
    set_wave(20, 20); run(100);
    bus.enable = 1'b0; run(30); bus.enable = 1'b1; run(150);
    repeat (40) begin
      set_wave($urandom_range(2, 60), $urandom_range(2, 60));
      if ($urandom_range(0, 7) == 0) begin
        bus.enable = 1'b0;
        run($urandom_range(1, 20));
        bus.enable = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        run(1);
        reset = 1'b0;
      end
      run($urandom_range(50, 300));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
